// File: rtl/dsp_mem_pkg.sv
// Shared definitions for the dual-dsp memory arbiter: default widths, FSM encoding
// and counter widths used by the arbiter and its round-robin picker.
package dsp_mem_pkg;

  localparam int DATA_W_DEF = 14;
  localparam int ADDR_W_DEF = 6;
  localparam int STALL_W    = 16;
  localparam int BEAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dsp_mem_rr_pick.sv
// Round-robin picker for two requesters: a lone requester wins outright,
// a tie goes to whichever requester did not own the memory last.
module dsp_mem_rr_pick (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_owner;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/dsp_mem_arb.sv
// Two-dsp arbiter for one single-port memory: registered grants with bounded bursts,
// in-order read return on a shared bus, and a saturating stall counter.
module dsp_mem_arb
  import dsp_mem_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req0,
  input  logic               req1,
  input  logic               we0,
  input  logic               we1,
  input  logic [ADDR_W-1:0]  addr0,
  input  logic [ADDR_W-1:0]  addr1,
  input  logic [DATA_W-1:0]  wdata0,
  input  logic [DATA_W-1:0]  wdata1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               rvalid0,
  output logic               rvalid1,
  output logic [DATA_W-1:0]  rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_din,
  input  logic [DATA_W-1:0]  mem_dout,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [BEAT_CNT_W-1:0] BURST_LAST = BEAT_CNT_W'(MAX_BURST - 1);

  arb_state_t            state;
  logic                  last_owner;
  logic                  started;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic                  winner;
  logic                  cur_owner;
  logic                  own_req;
  logic                  other_req;
  logic                  burst_done;
  logic                  beat0;
  logic                  beat1;
  logic                  waiting;
  logic [DATA_W-1:0]     rdata_q;

  assign beat0      = req0 & gnt0;
  assign beat1      = req1 & gnt1;
  assign cur_owner  = (state == OWN1);
  assign own_req    = cur_owner ? req1 : req0;
  assign other_req  = cur_owner ? req0 : req1;
  assign burst_done = (beat_cnt == BURST_LAST);
  assign waiting    = (req0 & ~gnt0) | (req1 & ~gnt1);

  dsp_mem_rr_pick u_pick (
    .req        ({req1, req0}),
    .last_owner (last_owner),
    .winner     (winner)
  );

  // 'started' holds off the first grant until one full cycle after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      beat_cnt   <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      started    <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (started && (req0 || req1)) begin
            state <= winner ? OWN1 : OWN0;
            gnt0  <= ~winner;
            gnt1  <= winner;
          end
        end
        OWN0, OWN1: begin
          if (!own_req || (burst_done && other_req)) begin
            last_owner <= cur_owner;
            beat_cnt   <= '0;
            if (other_req) begin
              state <= cur_owner ? OWN0 : OWN1;
              gnt0  <= cur_owner;
              gnt1  <= ~cur_owner;
            end else begin
              state <= IDLE;
              gnt0  <= 1'b0;
              gnt1  <= 1'b0;
            end
          end else if (burst_done) begin
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
          gnt0     <= 1'b0;
          gnt1     <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (beat0) begin
      mem_en   = 1'b1;
      mem_we   = we0;
      mem_addr = addr0;
      mem_din  = wdata0;
    end else if (beat1) begin
      mem_en   = 1'b1;
      mem_we   = we1;
      mem_addr = addr1;
      mem_din  = wdata1;
    end
  end

  // Memory read data arrives one cycle after the beat; rdata_q keeps the bus stable between returns.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata_q <= '0;
    end else begin
      rvalid0 <= beat0 & ~we0;
      rvalid1 <= beat1 & ~we1;
      rdata_q <= rdata;
    end
  end

  assign rdata = (rvalid0 | rvalid1) ? mem_dout : rdata_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (waiting && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dsp_mem_arb.sv
// Table-driven bench for dsp_mem_arb: each row gives inputs and expected grants,
// a scoreboard queue predicts read returns and a counter predicts stall_cnt.
module tb_dsp_mem_arb;

  localparam int DATA_W    = 14;
  localparam int ADDR_W    = 6;
  localparam int MAX_BURST = 4;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rstn;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;
  logic [15:0]       stall_cnt;

  typedef struct {
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
  } vec_t;

  typedef struct {
    logic              owner;
    logic [DATA_W-1:0] data;
  } ret_t;

  vec_t              tbl[$];
  ret_t              ret_q[$];
  logic [DATA_W-1:0] shadow [DEPTH];
  logic [DATA_W-1:0] exp_rdata;
  logic [15:0]       exp_stall;
  int                checks = 0;
  int                errors = 0;

  logic [DATA_W-1:0] mem_array [DEPTH];
  logic              mem_written [DEPTH];
  logic              mem_init;

  dsp_mem_arb #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_word(input int a);
    logic [DATA_W-1:0] w;
    w = DATA_W'(a);
    return w ^ 14'h1ABC ^ 14'h0005;
  endfunction

  // Synchronous single-port memory with a one-cycle read latency.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem_written[i] <= 1'b0;
    end else if (mem_en) begin
      if (mem_we) begin
        mem_array[mem_addr]   <= mem_din;
        mem_written[mem_addr] <= 1'b1;
      end else begin
        mem_dout <= mem_written[mem_addr] ? mem_array[mem_addr] : init_word(int'(mem_addr));
      end
    end
  end

  function automatic vec_t mk(input int r0, input int w0, input int a0, input int d0,
                              input int r1, input int w1, input int a1, input int d1,
                              input int g0, input int g1);
    vec_t v;
    v.req0   = (r0 != 0);
    v.we0    = (w0 != 0);
    v.addr0  = ADDR_W'(a0);
    v.wdata0 = DATA_W'(d0);
    v.req1   = (r1 != 0);
    v.we1    = (w1 != 0);
    v.addr1  = ADDR_W'(a1);
    v.wdata1 = DATA_W'(d1);
    v.gnt0   = (g0 != 0);
    v.gnt1   = (g1 != 0);
    return v;
  endfunction

  task automatic add(input int r0, input int w0, input int a0, input int d0,
                     input int r1, input int w1, input int a1, input int d1,
                     input int g0, input int g1);
    tbl.push_back(mk(r0, w0, a0, d0, r1, w1, a1, d1, g0, g1));
  endtask

  task automatic check_val(input string tag, input string what,
                           input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, what, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    req0   = v.req0;
    we0    = v.we0;
    addr0  = v.addr0;
    wdata0 = v.wdata0;
    req1   = v.req1;
    we1    = v.we1;
    addr1  = v.addr1;
    wdata1 = v.wdata1;
  endtask

  task automatic check_output(input vec_t v, input string tag);
    logic              exp_en, exp_we, exp_rv0, exp_rv1;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_din;
    ret_t              r;
    exp_en   = 1'b0;
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_din  = '0;
    if (v.req0 && v.gnt0) begin
      exp_en = 1'b1; exp_we = v.we0; exp_addr = v.addr0; exp_din = v.wdata0;
    end else if (v.req1 && v.gnt1) begin
      exp_en = 1'b1; exp_we = v.we1; exp_addr = v.addr1; exp_din = v.wdata1;
    end
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
    if (ret_q.size() > 0) begin
      r         = ret_q.pop_front();
      exp_rv0   = ~r.owner;
      exp_rv1   = r.owner;
      exp_rdata = r.data;
    end
    check_val(tag, "gnt0",      32'(gnt0),      32'(v.gnt0));
    check_val(tag, "gnt1",      32'(gnt1),      32'(v.gnt1));
    check_val(tag, "mem_en",    32'(mem_en),    32'(exp_en));
    check_val(tag, "mem_we",    32'(mem_we),    32'(exp_we));
    check_val(tag, "mem_addr",  32'(mem_addr),  32'(exp_addr));
    check_val(tag, "mem_din",   32'(mem_din),   32'(exp_din));
    check_val(tag, "rvalid0",   32'(rvalid0),   32'(exp_rv0));
    check_val(tag, "rvalid1",   32'(rvalid1),   32'(exp_rv1));
    check_val(tag, "rdata",     32'(rdata),     32'(exp_rdata));
    check_val(tag, "stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    if (exp_en && !exp_we) begin
      r.owner = v.gnt1;
      r.data  = shadow[exp_addr];
      ret_q.push_back(r);
    end
    if (exp_en && exp_we) shadow[exp_addr] = exp_din;
    if (((v.req0 && !v.gnt0) || (v.req1 && !v.gnt1)) && (exp_stall != 16'hFFFF))
      exp_stall = exp_stall + 16'd1;
  endtask

  task automatic run_row(input vec_t v, input string tag);
    apply_stimulus(v);
    @(negedge clk);
    check_output(v, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], $sformatf("%s%0d", tag, i));
    tbl.delete();
  endtask

  // Leaves rstn released just after a rising edge, so the next row sees edge 1 after release.
  task automatic do_reset(input int cycles);
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    apply_stimulus(idle);
    ret_q.delete();
    exp_stall = '0;
    exp_rdata = '0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check_output(idle, "reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    int   g0, g1, guard;

    for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
    mem_init  = 1'b1;
    exp_stall = '0;
    exp_rdata = '0;
    do_reset(3);
    mem_init = 1'b0;

    // Single read by requester 0: grant on the second edge, data one cycle later.
    add(1, 0, 5, 0,  0, 0, 0, 0,  0, 0);
    add(1, 0, 5, 0,  0, 0, 0, 0,  0, 0);
    add(1, 0, 5, 0,  0, 0, 0, 0,  1, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0,  1, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    run_table("single_rd");

    // Simultaneous requests from reset, handover without an idle cycle.
    do_reset(2);
    add(1, 0, 10, 0,  1, 0, 20, 0,  0, 0);
    add(1, 0, 10, 0,  1, 0, 20, 0,  0, 0);
    add(1, 0, 10, 0,  1, 0, 20, 0,  1, 0);
    add(0, 0, 0,  0,  1, 0, 20, 0,  1, 0);
    add(0, 0, 0,  0,  1, 0, 20, 0,  0, 1);
    add(0, 0, 0,  0,  0, 0, 0,  0,  0, 1);
    run_table("tie");

    // Write then a burst-limited switch: read order 0 then 1 across the switch.
    add(1, 1, 63, 16'h155,  1, 0, 63, 0,  0, 0);
    add(1, 1, 63, 16'h155,  1, 0, 63, 0,  1, 0);
    add(1, 0, 8,  0,        1, 0, 63, 0,  1, 0);
    add(1, 0, 9,  0,        1, 0, 63, 0,  1, 0);
    add(1, 0, 10, 0,        1, 0, 63, 0,  1, 0);
    add(1, 0, 11, 0,        1, 0, 63, 0,  0, 1);
    add(0, 0, 0,  0,        0, 0, 0,  0,  0, 1);
    add(0, 0, 0,  0,        0, 0, 0,  0,  0, 0);
    run_table("wr_rd");

    // Both requesters held: grants alternate in bursts of MAX_BURST.
    for (int k = 0; k < 20; k++) begin
      g0 = (k >= 1 && ((k - 1) / MAX_BURST) % 2 == 0) ? 1 : 0;
      g1 = (k >= 1 && ((k - 1) / MAX_BURST) % 2 == 1) ? 1 : 0;
      add(1, 0, k, 0,  1, 0, k + 32, 0,  g0, g1);
    end
    add(0, 0, 0, 0,  0, 0, 0, 0,  1, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    run_table("alt");

    // Requester 1 alone keeps its grant across burst boundaries.
    for (int k = 0; k < 12; k++) begin
      g1 = (k >= 1) ? 1 : 0;
      add(0, 0, 0, 0,  1, 0, k + 40, 0,  0, g1);
    end
    add(0, 0, 0, 0,  0, 0, 0, 0,  0, 1);
    add(0, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    run_table("solo1");

    // Long contention run until stall_cnt saturates.
    v = mk(1, 1, 0, 16'h0AA,  1, 1, 1, 16'h0BB,  0, 0);
    apply_stimulus(v);
    guard = 0;
    while (exp_stall != 16'hFFFE && guard < 70000) begin
      @(posedge clk);
      #1;
      exp_stall = exp_stall + 16'd1;
      guard++;
    end
    @(negedge clk);
    check_val("sat", "stall_pre", 32'(stall_cnt), 32'h0000FFFE);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("sat", "stall_max", 32'(stall_cnt), 32'h0000FFFF);

    // Reset during a read beat by requester 1: grant drops at once, no late rvalid.
    do_reset(2);
    add(0, 0, 0, 0,  1, 0, 30, 0,  0, 0);
    add(0, 0, 0, 0,  1, 0, 30, 0,  0, 0);
    run_table("mid_pre");
    v = mk(0, 0, 0, 0,  1, 0, 30, 0,  0, 1);
    apply_stimulus(v);
    @(negedge clk);
    check_output(v, "mid_beat");
    #1 rstn = 1'b0;
    #1;
    check_val("mid_rst", "gnt1",    32'(gnt1),    32'd0);
    check_val("mid_rst", "mem_en",  32'(mem_en),  32'd0);
    check_val("mid_rst", "rvalid1", 32'(rvalid1), 32'd0);
    ret_q.delete();
    exp_stall = '0;
    exp_rdata = '0;
    @(posedge clk);
    #1;
    check_val("mid_hold", "rvalid1",   32'(rvalid1),   32'd0);
    check_val("mid_hold", "gnt1",      32'(gnt1),      32'd0);
    check_val("mid_hold", "mem_en",    32'(mem_en),    32'd0);
    check_val("mid_hold", "rdata",     32'(rdata),     32'd0);
    check_val("mid_hold", "stall_cnt", 32'(stall_cnt), 32'd0);
    rstn = 1'b1;
    add(0, 0, 0, 0,  1, 0, 31, 0,  0, 0);
    add(0, 0, 0, 0,  1, 0, 31, 0,  0, 0);
    add(0, 0, 0, 0,  1, 0, 31, 0,  0, 1);
    add(0, 0, 0, 0,  0, 0, 0,  0,  0, 1);
    add(0, 0, 0, 0,  0, 0, 0,  0,  0, 0);
    run_table("mid_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_mem_arb.md
DSP_MEM_ARB -- requirements
Module: dsp_mem_arb

Interface
REQ-001 Parameter DATA_W, default 14, memory word width.
REQ-002 Parameter ADDR_W, default 6, memory address width (64 words).
REQ-003 Parameter MAX_BURST, default 4, beats one requester may take while the other waits; legal range 1..15.
REQ-004 Port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 Port rstn, input, 1, reset, asynchronous and active-low.
REQ-006 Ports req0/req1, input, 1 each, access request from dsp instance 0/1.
REQ-007 Ports we0/we1, input, 1 each, 1 = write, 0 = read.
REQ-008 Ports addr0/addr1, input, ADDR_W each, word address.
REQ-009 Ports wdata0/wdata1, input, DATA_W each, write data.
REQ-010 Ports gnt0/gnt1, output, 1 each, registered grant.
REQ-011 Ports rvalid0/rvalid1, output, 1 each, read-data-valid pulse.
REQ-012 Port rdata, output, DATA_W, shared read-return bus.
REQ-013 Ports mem_en, mem_we, output, 1 each, memory enable and write enable.
REQ-014 Ports mem_addr, output, ADDR_W, and mem_din, output, DATA_W, memory address and write data.
REQ-015 Port mem_dout, input, DATA_W, memory read data, valid one cycle after a read enable.
REQ-016 Port stall_cnt, output, 16, saturating count of cycles in which a request waited without a grant.

Function
REQ-017 FSM states IDLE, OWN0, OWN1; gnt0 = (state==OWN0), gnt1 = (state==OWN1); at most one grant high in any cycle.
REQ-018 A beat occurs in any cycle where reqN and gntN are both high; the memory is then driven combinationally from requester N: mem_en=1, mem_we=weN, mem_addr=addrN, mem_din=wdataN.
REQ-019 Outside a beat, mem_en=0, mem_we=0, and mem_addr/mem_din=0.
REQ-020 IDLE: if exactly one req is high, go to that owner; if both are high, go to the requester not in last_owner; otherwise stay IDLE.
REQ-021 OWNn, reqN low: go to the other owner if it requests, else IDLE; last_owner <= n.
REQ-022 OWNn, reqN high: count the beat in beat_cnt.
REQ-023 If beat_cnt reaches MAX_BURST and the other requester is high, switch to the other owner, set last_owner <= n, and clear beat_cnt.
REQ-024 If beat_cnt reaches MAX_BURST and the other requester is low, stay in OWNn and clear beat_cnt.
REQ-025 beat_cnt clears on every state change.
REQ-026 Grant latency: gnt rises one cycle after req is first sampled high in IDLE; no idle cycle is inserted on an owner switch.
REQ-027 A read beat in cycle t produces rvalidN=1 and rdata=mem_dout in cycle t+1, for one cycle, N being the owner at t.
REQ-028 Write beats produce no rvalid.
REQ-029 rdata holds its last value when no rvalid is high.
REQ-030 Read returns stay ordered across an owner switch: a read by 0 at t and a read by 1 at t+1 give rvalid0 at t+1 and rvalid1 at t+2.
REQ-031 stall_cnt increments by 1 per cycle in which any reqN is high with gntN low, saturating at 0xFFFF without wrap.

Reset
REQ-032 While rstn is low, the block is held in reset: state=IDLE, last_owner=1 (requester 0 wins the first tie), beat_cnt=0, gnt0/gnt1=0, rvalid0/rvalid1=0, rdata=0, stall_cnt=0, and the mem_* outputs are 0.
REQ-033 Reset asserted mid-burst or with a read in flight drops the grant immediately, and the pending rvalid is never issued after reset release.
REQ-034 After rstn deasserts, the first grant is issued no earlier than the second rising clk edge.

Structure
REQ-035 Shared package dsp_mem_pkg holds the DATA_W/ADDR_W defaults, the FSM state encoding, and the stall counter width.
REQ-036 Tie-break and rotation logic live in a sub-module dsp_mem_rr_pick: inputs req[1:0] and last_owner, output winner.
REQ-037 The FSM, beat counter, read-return pipeline, and stall counter live in dsp_mem_arb.

Verification
REQ-038 Scenario: reset, then req0=1 read at addr 5, memory word 0x1ABC -> gnt0 high at cycle 2, mem_addr=5, and in the next cycle rvalid0=1 with rdata=0x1ABC.
REQ-039 Scenario: req0 and req1 rise together from reset -> gnt0 first; when req0 drops, gnt1 follows next cycle with no idle cycle.
REQ-040 Scenario: both requesters held high for 20 cycles with MAX_BURST=4 -> grants alternate 4/4/4..., and stall_cnt increments once per cycle with one requester waiting.
REQ-041 Scenario: req1 alone held for 10 cycles -> gnt1 continuous, beat_cnt wraps silently, and stall_cnt stays 0.
REQ-042 Scenario: rstn pulsed low during a read beat by requester 1 -> gnt1, mem_en, and rvalid1 are all 0 immediately and after release.
REQ-043 Scenario: writes 0x0155 to addr 63 by requester 0, then a read of addr 63 by requester 1 -> rvalid1 with rdata=0x0155, and stall_cnt saturates at 0xFFFF in a long-contention run.
